disp_scan_formatter: RTL
========================

# disp_scan_formatter

Requester side of the display query interface: steps `display_number` through every entry, samples the registered `display_valid`/`display_name`/`display_value` response, and serialises each valid entry as a 16-byte ASCII text line. The line format is `NNNNN:HHHHHHHH\r\n`. Output goes to a byte sink over a valid/ready handshake, such as a UART transmitter or text-mode LCD writer. It sits beside the CPU display top, in place of or parallel to the touch-LCD controller, and polls the same per-entry data source.

## Interface
- `NUM_ENTRIES`, default 36: highest entry number queried. Entries run 1..NUM_ENTRIES; 0 is never issued. Legal range 1..63.
- `RESP_LATENCY`, default 1: number of register stages between `display_number` and the response inside the data source.
- `FRAME_GAP`, default 0: idle cycles after the last entry before the next frame starts.
- `clk` in 1: system clock. All logic is rising-edge.
- `resetn` in 1: reset, synchronous, active-low.
- `display_number` out 6: entry currently queried.
- `display_valid` in 1: entry exists. Sampled only in CAPTURE.
- `display_name` in 40: five ASCII characters, MSB byte first.
- `display_value` in 32: entry value.
- `char_valid` out 1: `char_data` holds a byte.
- `char_data` out 8: ASCII byte.
- `char_ready` in 1: sink accepts the byte on a cycle where `char_valid && char_ready`.
- `frame_done` out 1: one-cycle pulse when the last entry of a frame is finished, whether emitted or skipped.

## Operation
- FSM states: SET, WAIT, CAPTURE, EMIT, GAP.
- **SET**: `display_number` <= current entry n. Next state is WAIT.
- **WAIT**: count RESP_LATENCY cycles, then go to CAPTURE.
- **CAPTURE**:
  - If `display_valid`=1: latch name and value into a local 72-bit line buffer, set the char index to 0, and go to EMIT.
  - If `display_valid`=0: skip the entry and advance.
- **EMIT**:
  - Char index 0..15 maps to: name bytes [39:32]..[7:0]; 0x3A (`:`); value nibbles [31:28]..[3:0] as uppercase hex; 0x0D; 0x0A.
  - Hex encoding: nibble <10 gives 0x30+nibble, otherwise 0x37+nibble.
  - On handshake with index 15, advance.
- **Advance**:
  - If n < NUM_ENTRIES: n <= n+1, go to SET.
  - Otherwise: pulse `frame_done`, n <= 1, and go to GAP if FRAME_GAP>0, else SET.
- **GAP**: count FRAME_GAP cycles, then go to SET.
- Handshake rules:
  - `char_valid` rises only in EMIT.
  - While `char_valid && !char_ready`, `char_data` and `char_valid` hold stable.
  - No byte is dropped or duplicated.
  - `char_valid` may stay high across consecutive bytes.
- Entry data is latched once per entry. Source changes during EMIT do not affect the line in flight.
- Reset mid-line: the line is abandoned and no further bytes are presented. After reset the scan restarts at entry 1.

## Timing
- Reset values:
  - `display_number`=0
  - `char_valid`=0
  - `char_data`=0
  - `frame_done`=0
  - state SET, n=1
- `display_number` updates at edge k. The response is sampled at edge k+1+RESP_LATENCY.
- First `char_valid` is at the edge after CAPTURE.
- With `char_ready` held at 1, a valid entry takes 1 (SET) + RESP_LATENCY + 1 (CAPTURE) + 16 cycles. A skipped entry takes 2+RESP_LATENCY cycles.
- `frame_done` asserts on the edge where the final advance occurs.
- No combinational path from any input to any output.

## Structure
- Package `disp_pkg` holds:
  - the state enum
  - constants `LINE_LEN`=16, `CH_COLON`=8'h3A, `CH_CR`=8'h0D, `CH_LF`=8'h0A
  - function `hex2ascii(nibble)`
- Single module. The byte multiplexer is a function of char index and the line buffer, registered into `char_data`. No sub-module is warranted.

## Test plan
- **Reset.** Hold `resetn`=0 for 3 cycles with random inputs → all outputs 0. After release, `display_number`=1 on the first edge.
- **Basic line.** Behavioural source with latency 1; entry 1 = `"   PC"`, value 0x00000004; `char_ready`=1 → 16 consecutive bytes 20 20 20 50 43 3A 30 30 30 30 30 30 30 34 0D 0A.
- **Hex range.** Value 0xDEADBEEF → value bytes 44 45 41 44 42 45 45 46. Value 0x0A9F0010 → 30 41 39 46 30 30 31 30.
- **Backpressure.** Random `char_ready` at 30% duty → byte stream identical to the `char_ready`=1 run, and `char_data` stable whenever `char_valid && !char_ready`.
- **Skip and wrap.** NUM_ENTRIES=40, source valid only for 1..36, FRAME_GAP=5 → entries 37..40 emit nothing; `frame_done` pulses once per frame; `display_number` returns to 1 exactly 6 cycles after the `frame_done` edge.
- **Reset mid-line.** Assert reset after byte 7 of an entry → `char_valid`=0 on the reset edge. After release, the next line is entry 1 from byte 0.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types, constants and helpers for the display scan formatter
// Contents: scan FSM state enum, text line constants, nibble-to-ASCII helper.
package disp_pkg;

    typedef enum logic [2:0] {
        ST_SET,
        ST_WAIT,
        ST_CAPTURE,
        ST_EMIT,
        ST_GAP
    } state_e;

    localparam int         LINE_LEN = 16;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/disp_scan_formatter.sv
// rtl/disp_scan_formatter.sv - polls display entries and serialises each valid one as "NNNNN:HHHHHHHH\r\n"
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   display_number               entry currently queried (1..NUM_ENTRIES, 0 in reset)
//   display_valid/name/value     registered response of the data source
//   char_valid/char_data         byte stream towards the sink
//   char_ready                   sink accepts byte when char_valid && char_ready
//   frame_done                   one-cycle pulse when the last entry of a frame is finished
module disp_scan_formatter
    import disp_pkg::*;
#(
    parameter int NUM_ENTRIES  = 36,
    parameter int RESP_LATENCY = 1,
    parameter int FRAME_GAP    = 0
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [5:0]  display_number,
    input  logic        display_valid,
    input  logic [39:0] display_name,
    input  logic [31:0] display_value,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        frame_done
);

    localparam int          CNT_W    = 16;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RESP_LATENCY - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(FRAME_GAP - 1);
    localparam logic [3:0]  IDX_LAST = 4'(LINE_LEN - 1);
    localparam logic [5:0]  N_LAST   = 6'(NUM_ENTRIES);

    state_e           state_q, state_d;
    logic [5:0]       n_q, n_d;
    logic [5:0]       num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [71:0]      line_q, line_d;
    logic [3:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             fd_q, fd_d;
    logic             advance;

    // Byte at position idx of the line held in {name[39:0], value[31:0]}.
    function automatic logic [7:0] line_char(input logic [3:0] idx, input logic [71:0] line);
        logic [71:0] name_sh;
        logic [31:0] val_sh;
        name_sh = line << {idx, 3'b000};
        val_sh  = line[31:0] << {idx - 4'd6, 2'b00};
        if (idx < 4'd5) begin
            return name_sh[71:64];
        end else if (idx == 4'd5) begin
            return CH_COLON;
        end else if (idx < 4'd14) begin
            return hex2ascii(val_sh[31:28]);
        end else if (idx == 4'd14) begin
            return CH_CR;
        end
        return CH_LF;
    endfunction

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        fd_d    = 1'b0;
        advance = 1'b0;

        case (state_q)
            ST_SET: begin
                num_d   = n_q;
                cnt_d   = '0;
                state_d = (RESP_LATENCY > 0) ? ST_WAIT : ST_CAPTURE;
            end
            ST_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (display_valid) begin
                    line_d  = {display_name, display_value};
                    idx_d   = 4'd0;
                    // First byte is presented on the same edge that latches the line,
                    // so an unstalled line occupies exactly LINE_LEN cycles.
                    valid_d = 1'b1;
                    data_d  = line_char(4'd0, line_d);
                    state_d = ST_EMIT;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_EMIT: begin
                if (valid_q && char_ready) begin
                    if (idx_q == IDX_LAST) begin
                        valid_d = 1'b0;
                        advance = 1'b1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = line_char(idx_d, line_q);
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_SET;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_SET;
        endcase

        if (advance) begin
            if (n_q < N_LAST) begin
                n_d     = n_q + 1'b1;
                state_d = ST_SET;
            end else begin
                fd_d    = 1'b1;
                n_d     = 6'd1;
                cnt_d   = '0;
                state_d = (FRAME_GAP > 0) ? ST_GAP : ST_SET;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_SET;
            n_q     <= 6'd1;
            num_q   <= 6'd0;
            cnt_q   <= '0;
            line_q  <= '0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            data_q  <= 8'd0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            fd_q    <= fd_d;
        end
    end

    assign display_number = num_q;
    assign char_valid     = valid_q;
    assign char_data      = data_q;
    assign frame_done     = fd_q;

endmodule
